// File: rtl/tc_pl_relay_pkg.sv
// rtl/tc_pl_relay_pkg.sv - shared state encoding and default timing constants for the relay sequencer
package tc_pl_relay_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK  = 2'd1,
    SETTLE = 2'd2
  } relay_state_e;

  localparam int RW_DEF         = 4;
  localparam int BREAK_CYC_DEF  = 16;
  localparam int SETTLE_CYC_DEF = 1000;

  // Down-counter width for the longer phase; never narrower than one bit.
  function automatic int cnt_width(input int break_cyc, input int settle_cyc);
    int m;
    int w;
    m = (break_cyc > settle_cyc) ? break_cyc : settle_cyc;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tc_pl_relay_timer.sv
// rtl/tc_pl_relay_timer.sv - loadable down-counter with zero flag for break/settle timing
module tc_pl_relay_timer #(
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q = '0;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tc_pl_cap_gain_relay_seq.sv
// rtl/tc_pl_cap_gain_relay_seq.sv - break-before-make gain relay sequencer with per-channel relay registers
module tc_pl_cap_gain_relay_seq
  import tc_pl_relay_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int RW         = RW_DEF,
  parameter int BREAK_CYC  = BREAK_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gset_en,
  input  logic [3:0]        gset_ch,
  input  logic [RW-1:0]     gset_relay,
  output logic              gset_busy,
  output logic              gset_relay_cmpt,
  output logic              gset_err,
  output logic [NCH*RW-1:0] relay
);

  localparam int            CW        = cnt_width(BREAK_CYC, SETTLE_CYC);
  localparam logic [CW-1:0] BREAK_LD  = CW'(BREAK_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [4:0]    NCH_W     = 5'(NCH);

  relay_state_e      state_q = IDLE;
  relay_state_e      state_d;
  logic [3:0]        ch_q    = '0;
  logic [3:0]        ch_d;
  logic [RW-1:0]     word_q  = '0;
  logic [RW-1:0]     word_d;
  logic [NCH*RW-1:0] relay_q = '0;
  logic [NCH*RW-1:0] relay_d;
  logic              busy_q  = 1'b0;
  logic              busy_d;
  logic              cmpt_q  = 1'b0;
  logic              cmpt_d;
  logic              err_q   = 1'b0;
  logic              err_d;

  logic              tmr_load;
  logic [CW-1:0]     tmr_val;
  logic              tmr_dec;
  logic              tmr_zero;

  logic [RW-1:0]     cur_word;
  logic              ch_ok;

  function automatic logic [NCH*RW-1:0] put_word(input logic [NCH*RW-1:0] v,
                                                 input logic [3:0]        sel,
                                                 input logic [RW-1:0]     w);
    logic [NCH*RW-1:0] r;
    r = v;
    for (int k = 0; k < NCH; k++) begin
      if (sel == 4'(k)) begin
        r[k*RW +: RW] = w;
      end
    end
    return r;
  endfunction

  assign ch_ok = ({1'b0, gset_ch} < NCH_W);

  always_comb begin
    cur_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gset_ch == 4'(k)) begin
        cur_word = relay_q[k*RW +: RW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    word_d   = word_q;
    relay_d  = relay_q;
    cmpt_d   = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = BREAK_LD;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gset_en) begin
          if (!ch_ok) begin
            err_d = 1'b1;
          end else if (gset_relay == cur_word) begin
            cmpt_d = 1'b1;
          end else begin
            // Open the contacts being released before closing any new ones.
            ch_d     = gset_ch;
            word_d   = gset_relay;
            relay_d  = put_word(relay_q, gset_ch, cur_word & gset_relay);
            tmr_load = 1'b1;
            tmr_val  = BREAK_LD;
            state_d  = BREAK;
          end
        end
      end
      BREAK: begin
        err_d = gset_en;
        if (tmr_zero) begin
          relay_d  = put_word(relay_q, ch_q, word_q);
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
          state_d  = SETTLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          // A request landing on the completing edge is dropped silently so
          // the completion pulse never shares a cycle with a rejection pulse.
          cmpt_d  = 1'b1;
          state_d = IDLE;
        end else begin
          err_d   = gset_en;
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      word_q  <= '0;
      relay_q <= '0;
      busy_q  <= 1'b0;
      cmpt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      word_q  <= word_d;
      relay_q <= relay_d;
      busy_q  <= busy_d;
      cmpt_q  <= cmpt_d;
      err_q   <= err_d;
    end
  end

  tc_pl_relay_timer #(
    .CW (CW)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign gset_busy       = busy_q;
  assign gset_relay_cmpt = cmpt_q;
  assign gset_err        = err_q;
  assign relay           = relay_q;

endmodule

// File: tb/tb_tc_pl_cap_gain_relay_seq.sv
// tb/tb_tc_pl_cap_gain_relay_seq.sv - self-checking bench for the gain relay sequencer
module tb_tc_pl_cap_gain_relay_seq;

  localparam int NCH = 2;
  localparam int RW  = 4;
  localparam int BC  = 2;
  localparam int SC  = 3;
  localparam int SEQ_LAT = BC + SC;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              gset_en = 1'b0;
  logic [3:0]        gset_ch = '0;
  logic [RW-1:0]     gset_relay = '0;
  logic              gset_busy;
  logic              gset_relay_cmpt;
  logic              gset_err;
  logic [NCH*RW-1:0] relay;

  tc_pl_cap_gain_relay_seq #(
    .NCH        (NCH),
    .RW         (RW),
    .BREAK_CYC  (BC),
    .SETTLE_CYC (SC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .gset_en         (gset_en),
    .gset_ch         (gset_ch),
    .gset_relay      (gset_relay),
    .gset_busy       (gset_busy),
    .gset_relay_cmpt (gset_relay_cmpt),
    .gset_err        (gset_err),
    .relay           (relay)
  );

  always #5 clk = ~clk;

  typedef struct {
    int  due;
    bit  is_err;
  } exp_t;

  typedef struct {
    logic [3:0] ch;
    logic [3:0] word;
    bit         is_err;
    int         lat;
    logic [7:0] mid;
    logic [7:0] fin;
  } vec_t;

  exp_t sb[$];
  vec_t vt[8];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   cmpt_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
  endtask

  // Scoreboard monitor: every pulse must match an expected entry due this cycle.
  always @(negedge clk) begin
    int idx;
    if (!rst && (gset_relay_cmpt || gset_err)) begin
      if (gset_relay_cmpt) cmpt_seen++;
      if (gset_relay_cmpt && gset_err) begin
        checks++;
        $display("FAIL pulse_overlap cyc=%0d got both pulses expected one", cyc);
      end
      idx = -1;
      for (int j = 0; j < sb.size(); j++) if (idx < 0 && sb[j].due == cyc) idx = j;
      if (idx < 0) begin
        checks++;
        $display("FAIL pulse_unexpected cyc=%0d got cmpt=%0b err=%0b expected none", cyc, gset_relay_cmpt, gset_err);
      end else begin
        chk("pulse_is_err", 32'(gset_err), 32'(sb[idx].is_err));
        chk("pulse_is_cmpt", 32'(gset_relay_cmpt), 32'(!sb[idx].is_err));
        sb.delete(idx);
      end
    end
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].due < cyc) begin
        checks++;
        $display("FAIL pulse_missing cyc=%0d got no pulse expected due=%0d err=%0b", cyc, sb[j].due, sb[j].is_err);
        sb.delete(j);
      end
    end
  end

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] ch, input logic [3:0] w, input bit is_err,
                       input int lat, input bit expect_pulse);
    @(posedge clk);
    #1;
    gset_en    = 1'b1;
    gset_ch    = ch;
    gset_relay = w;
    if (expect_pulse) sb.push_back('{due: cyc + 1 + lat, is_err: is_err});
    @(posedge clk);
    #1;
    gset_en = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) at_neg();
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    bit seq;
    seq = !v.is_err && (v.lat != 0);
    issue(v.ch, v.word, v.is_err, v.lat, 1'b1);
    at_neg();
    chk("mid_busy", 32'(gset_busy), 32'(seq));
    chk("mid_relay", 32'(relay), 32'(v.mid));
    if (seq) begin
      repeat (BC) at_neg();
      chk("make_relay", 32'(relay), 32'(v.fin));
      chk("make_busy", 32'(gset_busy), 32'd1);
    end
    drain();
    chk("fin_relay", 32'(relay), 32'(v.fin));
    chk("fin_busy", 32'(gset_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    //         ch     word     err lat      mid    fin
    vt[0] = '{4'd1, 4'b0110, 0, SEQ_LAT, 8'h00, 8'h60};
    vt[1] = '{4'd0, 4'b0011, 0, SEQ_LAT, 8'h60, 8'h63};
    vt[2] = '{4'd0, 4'b0110, 0, SEQ_LAT, 8'h62, 8'h66};
    vt[3] = '{4'd1, 4'b0110, 0, 0,       8'h66, 8'h66};
    vt[4] = '{4'd2, 4'b1111, 1, 0,       8'h66, 8'h66};
    vt[5] = '{4'd1, 4'b1001, 0, SEQ_LAT, 8'h06, 8'h96};
    vt[6] = '{4'd3, 4'b0001, 1, 0,       8'h96, 8'h96};
    vt[7] = '{4'd0, 4'b1111, 0, SEQ_LAT, 8'h96, 8'h9F};

    repeat (3) @(posedge clk);
    at_neg();
    chk("rst_relay", 32'(relay), 32'd0);
    chk("rst_busy", 32'(gset_busy), 32'd0);
    chk("rst_cmpt", 32'(gset_relay_cmpt), 32'd0);
    chk("rst_err", 32'(gset_err), 32'd0);
    rst = 1'b0;

    foreach (vt[i]) run_vec(vt[i]);

    // Second request issued while the first sequence is in SETTLE.
    issue(4'd0, 4'b0000, 1'b0, SEQ_LAT, 1'b1);
    @(posedge clk);
    issue(4'd1, 4'b0000, 1'b1, 0, 1'b1);
    at_neg();
    chk("settle_busy", 32'(gset_busy), 32'd1);
    chk("settle_relay", 32'(relay), 32'h90);
    drain();
    chk("settle_fin_relay", 32'(relay), 32'h90);

    // Reset during BREAK aborts with no completion.
    issue(4'd1, 4'b0110, 1'b0, SEQ_LAT, 1'b0);
    at_neg();
    chk("brk_busy", 32'(gset_busy), 32'd1);
    chk("brk_relay", 32'(relay), 32'h00);
    seen = cmpt_seen;
    rst = 1'b1;
    at_neg();
    chk("abort_relay", 32'(relay), 32'd0);
    chk("abort_busy", 32'(gset_busy), 32'd0);
    rst = 1'b0;
    repeat (SEQ_LAT + 4) at_neg();
    chk("abort_no_cmpt", 32'(cmpt_seen), 32'(seen));
    chk("abort_relay_held", 32'(relay), 32'd0);

    run_vec('{4'd0, 4'b0001, 0, SEQ_LAT, 8'h00, 8'h01});

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tc_pl_cap_gain_relay_seq.md
TC_PL_CAP_GAIN_RELAY_SEQ -- requirements
Module: tc_pl_cap_gain_relay_seq

Interface
REQ-001 The block SHALL have these parameters:
- NCH, default 4: number of relay channels (1..16).
- RW, default 4: relay bits per channel, bit order per channel {OPX2,OPX1,10X2,10X1}.
- BREAK_CYC, default 16: break-phase duration in clk cycles (>=1).
- SETTLE_CYC, default 1000: settle duration in clk cycles (>=1).
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- gset_en  in  1  one-cycle request strobe.
- gset_ch  in  4  target channel index.
- gset_relay  in  RW  requested relay word.
- gset_busy  out  1  sequence in progress.
- gset_relay_cmpt  out  1  one-cycle completion pulse.
- gset_err  out  1  one-cycle rejection pulse.
- relay  out  NCH*RW  relay drive; channel k occupies bits [k*RW +: RW].

Function
REQ-003 The FSM SHALL have three states: IDLE, BREAK, SETTLE.
REQ-004 In IDLE, when gset_en=1 and gset_ch<NCH and gset_relay differs from the current word of that channel, the block SHALL, on that edge:
- latch ch and word;
- drive that channel to (old AND new), opening released contacts first;
- enter BREAK with the counter loaded to BREAK_CYC-1.
REQ-005 In BREAK with counter=0, the block SHALL drive the channel to the new word and enter SETTLE with the counter loaded to SETTLE_CYC-1; otherwise the counter SHALL decrement.
REQ-006 In SETTLE with counter=0, the block SHALL return to IDLE and pulse gset_relay_cmpt for exactly one cycle; otherwise the counter SHALL decrement.
REQ-007 Request latency SHALL be fixed: gset_relay_cmpt SHALL be high in the cycle BREAK_CYC+SETTLE_CYC edges after the sampling edge.
REQ-008 A request with a word equal to the current word SHALL skip BREAK and SETTLE: gset_relay_cmpt pulses on the next cycle, relay is unchanged, and gset_busy stays 0.
REQ-009 A request with gset_ch>=NCH SHALL pulse gset_err for one cycle and leave relay and the state unchanged.
REQ-010 A request while gset_busy=1 SHALL be dropped (not queued) and SHALL pulse gset_err; the sequence in progress SHALL be unaffected.
REQ-011 gset_busy SHALL be 1 exactly while the state is BREAK or SETTLE.
REQ-012 Channels other than the latched channel SHALL never change during a sequence.
REQ-013 gset_relay_cmpt and gset_err SHALL never be high in the same cycle.
REQ-014 All outputs SHALL be registered.

Reset
REQ-015 When rst=1 at an edge, the block SHALL drive relay to all-zero, the state to IDLE, the counter to 0, and gset_busy, gset_relay_cmpt and gset_err to 0.
REQ-016 Reset SHALL take priority over gset_en, and a reset mid-sequence SHALL abort the sequence with no gset_relay_cmpt pulse.
REQ-017 The power-up register initial values SHALL equal the reset values.

Structure
REQ-018 A shared package tc_pl_relay_pkg SHALL hold the state enumeration (IDLE/BREAK/SETTLE) and the default constants for RW, BREAK_CYC and SETTLE_CYC.
REQ-019 The counter SHALL be sized to $clog2(max(BREAK_CYC,SETTLE_CYC)) bits.
REQ-020 One sub-module, tc_pl_relay_timer (load/decrement/zero-flag down-counter), SHALL implement the counter; the FSM and the relay register array SHALL stay in the top level.

Verification (NCH=2, RW=4, BREAK_CYC=2, SETTLE_CYC=3)
REQ-021 Reset, then gset_en with ch=1 and word 4'b0110 -> relay[7:4] goes 0000 -> 0000 (break) -> 0110 two edges later; gset_relay_cmpt is high 5 cycles after the request; gset_busy is high for 5 cycles.
REQ-022 ch=0 with current word 0011 and new word 0110 -> the break phase shows 0010, then 0110; relay[7:4] is untouched throughout.
REQ-023 Repeat of word 0110 on ch=1 -> gset_relay_cmpt on the next cycle, gset_busy stays 0, relay is unchanged.
REQ-024 gset_ch=2 -> one-cycle gset_err pulse, no relay change; a second request issued during SETTLE -> gset_err pulse, and the first sequence completes on time.
REQ-025 rst asserted during BREAK -> relay=0 on the next cycle, and no gset_relay_cmpt pulse follows.
